pcie_dll_tx_replay: RTL
=======================

# pcie_dll_tx_replay

Data Link Layer transmit stage directly downstream of the TL VC arbiter. Accepts one 224-bit TLP per cycle over valid/ready, tags each with a 12-bit sequence number and a 32-bit LCRC, and emits a 272-bit LPDU. Every transmitted TLP is kept in a replay buffer until the link partner ACKs it. A NAK replays all unacknowledged TLPs in order.

## Interface
- `REPLAY_DEPTH`, 8: replay buffer entries; power of 2, 2..2048.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tlp_valid_i` in 1: TLP offered by the arbiter.
- `tlp_i` in 224: TLP payload.
- `tlp_ready_o` out 1: stage can accept a TLP this cycle (combinational).
- `lpdu_valid_o` out 1: LPDU output valid (registered).
- `lpdu_o` out 272: {4'b0, seq[11:0], tlp[223:0], lcrc[31:0]} (registered).
- `lpdu_ready_i` in 1: downstream (framer) accepts the LPDU.
- `ack_valid_i` in 1: ACK DLLP received, 1-cycle pulse.
- `nak_valid_i` in 1: NAK DLLP received, 1-cycle pulse.
- `acknak_seq_i` in 12: AckNak_Seq_Num carried by the DLLP.
- `replay_busy_o` out 1: state is REPLAY.
- `protocol_err_o` out 1: 1-cycle pulse when an ACK/NAK sequence number is out of range.
- `retrain_req_o` out 1: 1-cycle pulse when REPLAY_NUM rolls over.

## Operation
- **Registers and reset values:**
  - NEXT_SEQ = 0, ACKD_SEQ = 4095, count = 0, wr_ptr = 0, rd_ptr = 0, REPLAY_NUM = 0, state = NORMAL.
  - All outputs 0 during reset.
- **Sequence arithmetic:** modulo 4096. d(a,b) = (a − b) mod 4096.
- **Output slot:** one output register. `slot_free = !lpdu_valid_o || lpdu_ready_i`. The LPDU is held stable while `lpdu_ready_i` = 0.
- **Ready:** `tlp_ready_o = (state==NORMAL) && (count < REPLAY_DEPTH) && slot_free`.
  - Must not depend on `tlp_valid_i`, because the arbiter's valid depends on this ready.
- **Accept** (`tlp_valid_i && tlp_ready_o`):
  - Write {NEXT_SEQ, tlp} to the buffer at wr_ptr.
  - Load the output register with the LPDU.
  - wr_ptr++, count++, NEXT_SEQ++.
- **LCRC:** CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, processed MSB-first over the 240-bit {4'b0, seq, tlp}, final result complemented. Computed whenever the output register is loaded, including replays.
- **ACK/NAK range check (NORMAL only):** the number is valid iff d(acknak_seq_i, ACKD_SEQ) ≤ count.
  - A valid number purges n = d(acknak_seq_i, ACKD_SEQ) entries: rd_ptr += n, count −= n, ACKD_SEQ = acknak_seq_i.
  - An invalid number causes no state change and pulses `protocol_err_o`.
- **ACK:**
  - Purge.
  - If n > 0, REPLAY_NUM = 0.
- **NAK:**
  - Purge.
  - If the remaining count > 0: REPLAY_NUM++ and enter REPLAY.
  - If REPLAY_NUM was 3, it wraps to 0 and `retrain_req_o` pulses; the replay still occurs.
- **ACK and NAK in the same cycle:** treated as NAK.
- **Accept concurrent with ACK/NAK:** count = count + 1 − n. The new entry is not replayed by this NAK.
- **REPLAY state:**
  - Replays `replay_cnt` = count entries, starting at rd_ptr, with their original sequence numbers.
  - One entry is loaded per cycle while `slot_free`.
  - Returns to NORMAL on the cycle the last replayed entry is loaded.
  - No new TLPs are accepted during REPLAY.
  - `ack_valid_i` and `nak_valid_i` are ignored in REPLAY (no error pulse).
  - A frame already in the output register at NAK time completes normally. The receiver discards the resulting duplicate.
- **Reset mid-operation:** buffer contents are abandoned and all state returns to reset values.

## Timing
- TLP accepted at edge T → `lpdu_valid_o` high from T+1. Throughput is 1 LPDU per cycle when `lpdu_ready_i` = 1.
- NAK sampled at edge T → `replay_busy_o` high from T+1 → first replayed LPDU valid from T+2, provided the slot is free. A replay of k entries occupies k cycles with no backpressure.
- ACK sampled at T → purge is visible at T+1. `tlp_ready_o` can rise at T+1 if the buffer was full.
- `protocol_err_o` and `retrain_req_o` are registered and pulse in cycle T+1.

## Structure
- Package `pcie_dll_pkg`:
  - `SEQ_W` = 12, `LPDU_W` = 272, `TLP_W` = 224.
  - `seq_t` typedef.
  - State enum {ST_NORMAL, ST_REPLAY}.
  - `seq_diff()` function.
- Sub-module `pcie_lcrc32`: purely combinational, 240-bit data in, 32-bit LCRC out. Instantiated once, on the output-register load path.
- Replay buffer is an inferred RAM of REPLAY_DEPTH × 236 bits (seq + TLP).

## Test plan
- **Reset and basic flow:**
  - Release reset, send 3 TLPs back-to-back with `lpdu_ready_i` = 1.
  - Expect LPDUs with seq 0, 1, 2 on consecutive cycles, starting one cycle after each accept.
  - LCRC must match the golden model.
- **Full buffer and ACK release:**
  - With `REPLAY_DEPTH` = 8 and no ACKs, after 8 accepts `tlp_ready_o` = 0.
  - ACK with seq 3 → count = 4, and `tlp_ready_o` = 1 the next cycle.
- **NAK replay:**
  - After seq 0–5 are sent, NAK with seq 1 → replays seq 2, 3, 4, 5 in order with identical payloads.
  - `replay_busy_o` is high for the duration. The next new TLP receives seq 6.
- **Backpressure:**
  - Hold `lpdu_ready_i` = 0 for 5 cycles mid-stream, both in NORMAL and in REPLAY.
  - `lpdu_o` stays stable and `tlp_ready_o` = 0.
- **Invalid ACK:** after sending seq 0–2, ACK with seq 10 → `protocol_err_o` pulses once and count stays 3.
- **REPLAY_NUM rollover and wrap-around:**
  - Four NAKs with no progressing ACK → `retrain_req_o` pulses on the 4th.
  - Separately, send 4100 TLPs with periodic ACKs → seq wraps from 4095 to 0 with no error.

Source files
------------

// File: rtl/pcie_dll_pkg.sv
// Shared types and helpers for the PCIe DLL transmit/replay stage.
package pcie_dll_pkg;

  localparam int SEQ_W    = 12;
  localparam int TLP_W    = 224;
  localparam int LPDU_W   = 272;
  localparam int CRC_IN_W = LPDU_W - 32;   // {4'b0, seq, tlp}
  localparam int ENTRY_W  = SEQ_W + TLP_W; // replay buffer word

  localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic {ST_NORMAL, ST_REPLAY} dll_state_t;

  // Sequence-number distance a - b modulo 4096.
  function automatic seq_t seq_diff(input seq_t a, input seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/pcie_dll_tx_replay_if.sv
// TLP input, LPDU output and ACK/NAK status bundle of the DLL transmit stage.
interface pcie_dll_tx_replay_if;
  import pcie_dll_pkg::*;

  logic              tlp_valid_i;
  logic [TLP_W-1:0]  tlp_i;
  logic              tlp_ready_o;
  logic              lpdu_valid_o;
  logic [LPDU_W-1:0] lpdu_o;
  logic              lpdu_ready_i;
  logic              ack_valid_i;
  logic              nak_valid_i;
  seq_t              acknak_seq_i;
  logic              replay_busy_o;
  logic              protocol_err_o;
  logic              retrain_req_o;

  // Environment side: arbiter, framer and DLLP receiver.
  modport master (
    output tlp_valid_i, tlp_i, lpdu_ready_i, ack_valid_i, nak_valid_i, acknak_seq_i,
    input  tlp_ready_o, lpdu_valid_o, lpdu_o, replay_busy_o, protocol_err_o, retrain_req_o
  );

  // DLL transmit stage side.
  modport slave (
    input  tlp_valid_i, tlp_i, lpdu_ready_i, ack_valid_i, nak_valid_i, acknak_seq_i,
    output tlp_ready_o, lpdu_valid_o, lpdu_o, replay_busy_o, protocol_err_o, retrain_req_o
  );

endinterface

// File: rtl/pcie_lcrc32.sv
// Combinational LCRC: CRC-32 (0x04C11DB7), init all-ones, MSB first, result inverted.
module pcie_lcrc32
  import pcie_dll_pkg::*;
(
  input  logic [CRC_IN_W-1:0] data,
  output logic [31:0]         lcrc
);

  function automatic logic [31:0] crc32_msb(input logic [CRC_IN_W-1:0] d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ LCRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return ~c;
  endfunction

  // Fully unrolled bit-serial division over the whole LPDU header+payload.
  always_comb begin
    lcrc = crc32_msb(data);
  end

endmodule

// File: rtl/pcie_dll_tx_replay.sv
// DLL transmit stage: sequence numbering, LCRC, replay buffer and ACK/NAK handling.
module pcie_dll_tx_replay
  import pcie_dll_pkg::*;
#(
  parameter int REPLAY_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcie_dll_tx_replay_if.slave  dll
);

  localparam int PTR_W = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = SEQ_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(REPLAY_DEPTH);

  dll_state_t state_q, state_d;
  seq_t       next_seq_q, ackd_seq_q;
  cnt_t       count_q, replay_cnt_q;
  ptr_t       wr_ptr_q, rd_ptr_q, replay_ptr_q;
  logic [1:0] replay_num_q;
  logic       err_q, rtr_q;
  logic       replay_busy;

  logic [ENTRY_W-1:0] buf_mem [REPLAY_DEPTH];

  // Output slot (stage p1)
  logic              vld_p1;
  logic [LPDU_W-1:0] lpdu_p1;

  logic               slot_free, tlp_ready, accept;
  logic               an_evt, an_ok, purge, bad_seq, nak_replay;
  seq_t               an_n;
  cnt_t               n_cnt, remain;
  logic               replay_load, replay_last, load;
  logic [ENTRY_W-1:0] load_entry;
  logic [CRC_IN_W-1:0] crc_in;
  logic [31:0]        lcrc;

  assign slot_free = !vld_p1 || dll.lpdu_ready_i;
  assign tlp_ready = rst_n && (state_q == ST_NORMAL) && (count_q < DEPTH_C) && slot_free;
  assign accept    = dll.tlp_valid_i && tlp_ready;

  // ACK/NAK are only honoured in NORMAL; a NAK wins over a simultaneous ACK.
  assign an_evt     = (state_q == ST_NORMAL) && (dll.ack_valid_i || dll.nak_valid_i);
  assign an_n       = seq_diff(dll.acknak_seq_i, ackd_seq_q);
  assign an_ok      = CMP_W'(an_n) <= CMP_W'(count_q);
  assign purge      = an_evt && an_ok;
  assign bad_seq    = an_evt && !an_ok;
  assign n_cnt      = purge ? cnt_t'(an_n) : '0;
  assign remain     = count_q - n_cnt;
  assign nak_replay = purge && dll.nak_valid_i && (remain != '0);

  assign replay_load = (state_q == ST_REPLAY) && slot_free;
  assign replay_last = replay_load && (replay_cnt_q == cnt_t'(1));
  assign load        = accept || replay_load;

  // Replays reuse the stored {seq, tlp}; fresh TLPs take the next sequence number.
  always_comb begin
    load_entry = {next_seq_q, dll.tlp_i};
    if (replay_load) load_entry = buf_mem[replay_ptr_q];
  end

  assign crc_in = {4'b0000, load_entry};

  pcie_lcrc32 u_lcrc (
    .data (crc_in),
    .lcrc (lcrc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  // FSM next state: enter REPLAY on a NAK with outstanding entries, leave on the last load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (nak_replay)  state_d = ST_REPLAY;
      ST_REPLAY: if (replay_last) state_d = ST_NORMAL;
      default:                    state_d = ST_NORMAL;
    endcase
  end

  // FSM outputs.
  always_comb begin
    replay_busy = (state_q == ST_REPLAY);
  end

  // Replay buffer write: every accepted TLP is retained with its sequence number.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_ptr_q] <= {next_seq_q, dll.tlp_i};
  end

  // Sequence, pointer, count and replay bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_seq_q   <= '0;
      ackd_seq_q   <= '1;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      replay_num_q <= '0;
      replay_cnt_q <= '0;
      replay_ptr_q <= '0;
      err_q        <= 1'b0;
      rtr_q        <= 1'b0;
    end else begin
      err_q <= bad_seq;
      rtr_q <= nak_replay && (replay_num_q == 2'd3);
      if (accept) begin
        next_seq_q <= next_seq_q + seq_t'(1);
        wr_ptr_q   <= wr_ptr_q + ptr_t'(1);
      end
      count_q <= count_q + cnt_t'(accept) - n_cnt;
      if (purge) begin
        rd_ptr_q   <= rd_ptr_q + ptr_t'(n_cnt);
        ackd_seq_q <= dll.acknak_seq_i;
        if (dll.nak_valid_i) begin
          if (remain != '0) replay_num_q <= replay_num_q + 2'd1;
        end else if (an_n != '0) begin
          replay_num_q <= '0;
        end
      end
      if (nak_replay) begin
        replay_cnt_q <= remain;
        replay_ptr_q <= rd_ptr_q + ptr_t'(n_cnt);
      end else if (replay_load) begin
        replay_cnt_q <= replay_cnt_q - cnt_t'(1);
        replay_ptr_q <= replay_ptr_q + ptr_t'(1);
      end
    end
  end

  // Output slot load: hold while the framer stalls, clear once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      lpdu_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      lpdu_p1 <= {crc_in, lcrc};
    end else if (dll.lpdu_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dll.tlp_ready_o    = tlp_ready;
  assign dll.lpdu_valid_o   = vld_p1;
  assign dll.lpdu_o         = lpdu_p1;
  assign dll.replay_busy_o  = replay_busy;
  assign dll.protocol_err_o = err_q;
  assign dll.retrain_req_o  = rtr_q;

endmodule
